// File: rtl/timer_bank_pkg.sv
// Register map, CTRL bit positions and window helpers shared by the timer bank
// top level and its channels.
package timer_bank_pkg;

  localparam int REGS_PER_CH = 4;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_RELOAD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_IEN = 2;
  localparam int CTRL_W   = 3;

  // The shared PRESC register sits immediately after the last channel block.
  function automatic logic [15:0] presc_off(input int n_ch);
    return 16'(REGS_PER_CH * n_ch);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/RELOAD/COUNT registers plus a sticky
// pending flag, advanced by the shared prescaler tick.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              ctrl_we_i,
  input  logic              reload_we_i,
  input  logic              pend_clr_i,
  input  logic [15:0]       wdata_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  reload_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              pend_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  reload_q, reload_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_q, pend_d;
  logic              run_s, expire_s, en_rise_s;

  // Next-state: enable edge and idle RELOAD writes load COUNT ahead of any tick.
  always_comb begin
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    pend_d    = pend_q;
    run_s     = tick_i & ctrl_q[CTRL_EN];
    expire_s  = run_s & (count_q == '0);
    en_rise_s = ctrl_we_i & wdata_i[CTRL_EN] & ~ctrl_q[CTRL_EN];

    if (en_rise_s) begin
      count_d = reload_q;
    end else if (reload_we_i && !ctrl_q[CTRL_EN]) begin
      count_d = wdata_i[CNT_W-1:0];
    end else if (expire_s) begin
      count_d = ctrl_q[CTRL_PER] ? reload_q : count_q;
    end else if (run_s) begin
      count_d = count_q - CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end

    if (ctrl_we_i) begin
      ctrl_d = wdata_i[CTRL_W-1:0];
    end else if (expire_s && !ctrl_q[CTRL_PER]) begin
      ctrl_d = {ctrl_q[CTRL_IEN], ctrl_q[CTRL_PER], 1'b0};
    end else begin
      ctrl_d = ctrl_q;
    end

    if (reload_we_i) begin
      reload_d = wdata_i[CNT_W-1:0];
    end else begin
      reload_d = reload_q;
    end

    // Expiry beats a same-edge write-1-to-clear so no event is lost.
    if (expire_s) begin
      pend_d = 1'b1;
    end else if (pend_clr_i) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      reload_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign reload_o = reload_q;
  assign count_o  = count_q;
  assign pend_o   = pend_q;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of N_CH down-counting timers sharing one prescaler; decodes
// the bus window, muxes read data and packs the masked pending flags into irq.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          N_CH      = 4,
  parameter int          IRQ_W     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [15:0] PRESC_RST = 16'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             oe,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  output logic             hit,
  output logic [IRQ_W-1:0] irq
);

  localparam logic [15:0] PRESC_OFF = presc_off(N_CH);

  logic [15:0]            off_s;
  logic                   presc_sel_s;
  logic                   tick_s;
  logic [15:0]            presc_q, presc_d;
  logic [15:0]            pcnt_q, pcnt_d;
  logic [N_CH-1:0]        pend_s;
  logic [N_CH-1:0]        ien_s;
  logic [N_CH-1:0][15:0]  word_s;
  logic [15:0]            rd_s;

  assign off_s       = addr - BASE_ADDR;
  assign hit         = (addr >= BASE_ADDR) && (off_s <= PRESC_OFF);
  assign presc_sel_s = hit && (off_s == PRESC_OFF);
  assign tick_s      = (pcnt_q == presc_q);

  // Prescaler next-state; a PRESC write restarts the tick phase.
  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (we && presc_sel_s) begin
      presc_d = wdata;
      pcnt_d  = 16'h0000;
    end else if (tick_s) begin
      pcnt_d  = 16'h0000;
    end else begin
      pcnt_d  = pcnt_q + 16'h0001;
    end
  end

  // Prescaler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= PRESC_RST;
      pcnt_q  <= 16'h0000;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic              sel_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [CNT_W-1:0]  reload_s;
    logic [CNT_W-1:0]  count_s;

    assign sel_s = hit && (off_s[15:2] == 14'(g));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick_i      (tick_s),
      .ctrl_we_i   (we && sel_s && (off_s[1:0] == OFF_CTRL)),
      .reload_we_i (we && sel_s && (off_s[1:0] == OFF_RELOAD)),
      .pend_clr_i  (we && sel_s && (off_s[1:0] == OFF_STATUS) && wdata[0]),
      .wdata_i     (wdata),
      .ctrl_o      (ctrl_s),
      .reload_o    (reload_s),
      .count_o     (count_s),
      .pend_o      (pend_s[g])
    );

    assign ien_s[g]  = ctrl_s[CTRL_IEN];
    assign word_s[g] = (off_s[1:0] == OFF_CTRL)   ? 16'(ctrl_s)   :
                       (off_s[1:0] == OFF_RELOAD) ? 16'(reload_s) :
                       (off_s[1:0] == OFF_COUNT)  ? 16'(count_s)  :
                                                    {15'h0000, pend_s[g]};
  end

  // Read mux: at most one channel index matches, so an OR-select suffices.
  always_comb begin
    rd_s = 16'h0000;
    if (oe && presc_sel_s) begin
      rd_s = presc_q;
    end else if (oe && hit) begin
      for (int i = 0; i < N_CH; i++) begin
        rd_s = rd_s | (word_s[i] & {16{off_s[15:2] == 14'(i)}});
      end
    end else begin
      rd_s = 16'h0000;
    end
  end

  assign rdata = rd_s;
  assign irq   = IRQ_W'(pend_s & ien_s);

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: reset, periodic, one-shot, W1C race, masking,
// window decode and live RELOAD update with hand-computed expectations.
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        oe;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        hit;
  logic [7:0]  irq;

  int checks = 0;
  int errors = 0;

  timer_bank #(
    .N_CH(4), .IRQ_W(8), .CNT_W(16), .BASE_ADDR(16'hFF00), .PRESC_RST(16'd0)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .oe(oe), .addr(addr), .wdata(wdata),
    .rdata(rdata), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr = a;
    oe   = 1'b1;
    #1;
    chk(tag, 32'(rdata), 32'(exp));
    oe   = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    oe    = 1'b0;
    addr  = 16'h0000;
    wdata = 16'h0000;
    #22 reset = 1'b1;
    step(1);

    chk("rst_irq", 32'(irq), 32'h00);
    addr = 16'hFF00;
    #1;
    chk("rst_rdata_oe0", 32'(rdata), 32'h0000);
    chk("rst_hit", 32'(hit), 32'h1);
    rd(16'hFF10, 16'h0000, "rst_presc");
    rd(16'hFF02, 16'h0000, "rst_count0");

    // PRESC=3; CTRL write lands on a tick edge, so expiry is 6 ticks = 24 clks later
    write(16'hFF10, 16'd3);
    write(16'hFF01, 16'd5);
    step(2);
    write(16'hFF00, 16'h0007);
    rd(16'hFF02, 16'd5, "per_cnt_load");
    rd(16'hFF00, 16'h0007, "per_ctrl");
    step(4);
    rd(16'hFF02, 16'd4, "per_cnt_tick1");
    step(16);
    rd(16'hFF02, 16'd0, "per_cnt_zero");
    step(3);
    chk("per_irq_before", 32'(irq), 32'h00);
    step(1);
    chk("per_irq_rise", 32'(irq), 32'h01);
    rd(16'hFF02, 16'd5, "per_cnt_reload");
    rd(16'hFF03, 16'd1, "per_status");
    write(16'hFF03, 16'h0001);
    chk("per_w1c", 32'(irq), 32'h00);
    step(22);
    chk("per_irq_gap", 32'(irq), 32'h00);
    step(1);
    chk("per_irq_repeat", 32'(irq), 32'h01);

    // asynchronous reset in the middle of a count
    reset = 1'b0;
    #1;
    chk("rst_mid_irq", 32'(irq), 32'h00);
    rd(16'hFF02, 16'h0000, "rst_mid_count0");
    rd(16'hFF00, 16'h0000, "rst_mid_ctrl0");
    rd(16'hFF10, 16'h0000, "rst_mid_presc");
    reset = 1'b1;
    step(1);

    // one-shot on ch1 with PRESC=0
    write(16'hFF05, 16'd2);
    write(16'hFF04, 16'h0005);
    step(2);
    chk("os_irq_early", 32'(irq), 32'h00);
    step(1);
    chk("os_irq_set", 32'(irq), 32'h02);
    rd(16'hFF04, 16'h0004, "os_ctrl_en_off");
    rd(16'hFF06, 16'h0000, "os_count");
    write(16'hFF07, 16'h0001);
    chk("os_w1c", 32'(irq), 32'h00);
    step(5);
    rd(16'hFF07, 16'h0000, "os_no_repend");
    chk("os_irq_quiet", 32'(irq), 32'h00);

    // W1C lands on the expiry edge: set wins
    write(16'hFF01, 16'd2);
    write(16'hFF00, 16'h0007);
    step(2);
    write(16'hFF03, 16'h0001);
    chk("race_irq", 32'(irq), 32'h01);
    rd(16'hFF03, 16'h0001, "race_status");
    write(16'hFF00, 16'h0000);
    rd(16'hFF02, 16'd1, "freeze_count_a");
    step(3);
    rd(16'hFF02, 16'd1, "freeze_count_b");
    rd(16'hFF03, 16'h0001, "freeze_pend");
    write(16'hFF03, 16'h0001);
    chk("freeze_w1c", 32'(irq), 32'h00);

    // masked expiry on ch2, then unmask; decode boundaries
    write(16'hFF09, 16'd1);
    write(16'hFF08, 16'h0001);
    step(2);
    rd(16'hFF0B, 16'h0001, "mask_status");
    chk("mask_irq", 32'(irq), 32'h00);
    write(16'hFF08, 16'h0004);
    chk("unmask_irq", 32'(irq), 32'h04);
    rd(16'hFF0E, 16'h0000, "ch3_count");
    rd(16'hFF0C, 16'h0000, "ch3_ctrl");
    addr = 16'hFF11;
    oe   = 1'b1;
    #1;
    chk("out_hit", 32'(hit), 32'h0);
    chk("out_rdata", 32'(rdata), 32'h0000);
    oe   = 1'b0;
    write(16'hFF11, 16'hFFFF);
    write(16'hFEFF, 16'hFFFF);
    rd(16'hFF10, 16'h0000, "out_write_ignored");
    chk("presc_hit", 32'(hit), 32'h1);
    write(16'hFF0B, 16'h0001);
    chk("mask_w1c", 32'(irq), 32'h00);

    // RELOAD rewritten while ch0 runs: current period unchanged, next ones 2 ticks
    write(16'hFF01, 16'd5);
    write(16'hFF00, 16'h0007);
    write(16'hFF01, 16'd1);
    rd(16'hFF02, 16'd4, "live_cnt");
    step(4);
    chk("live_irq_before", 32'(irq), 32'h00);
    rd(16'hFF02, 16'd0, "live_cnt_zero");
    step(1);
    chk("live_irq_first", 32'(irq), 32'h01);
    rd(16'hFF02, 16'd1, "live_cnt_new");
    write(16'hFF03, 16'h0001);
    chk("live_w1c", 32'(irq), 32'h00);
    step(1);
    chk("live_irq_short", 32'(irq), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
